// File: rtl/pa_lsu_wb_drain_pkg.sv
// Shared LSU definitions for the write-buffer drain path.
// Holds AHB transfer encodings, drain FSM states and default sizing.
package pa_lsu_wb_drain_pkg;

  localparam int ENTRY_DEF = 4;
  localparam int PTRW_DEF  = 2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_DPH  = 2'd1,
    DRAIN_ERR  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/pa_lsu_wb_drain_mux.sv
// Selects the fields of one write-buffer entry by pointer.
// The pointer is decoded to one-hot and the fields are AND-OR muxed.
module pa_lsu_wb_drain_mux
  import pa_lsu_wb_drain_pkg::*;
#(
  parameter int ENTRY = ENTRY_DEF,
  parameter int PTRW  = PTRW_DEF
) (
  input  logic [PTRW-1:0]     sel_idx,
  input  logic [ENTRY-1:0]    addr_vld,
  input  logic [ENTRY-1:0]    data_vld,
  input  logic [32*ENTRY-1:0] addr,
  input  logic [2*ENTRY-1:0]  size,
  input  logic [4*ENTRY-1:0]  prot,
  input  logic [32*ENTRY-1:0] wdata,
  input  logic [ENTRY-1:0]    so,
  output logic [ENTRY-1:0]    sel_oh,
  output logic                sel_addr_vld,
  output logic                sel_data_vld,
  output logic [31:0]         sel_addr,
  output logic [1:0]          sel_size,
  output logic [3:0]          sel_prot,
  output logic [31:0]         sel_wdata,
  output logic                sel_so
);

  always_comb begin
    sel_oh          = '0;
    sel_oh[sel_idx] = 1'b1;
  end

  always_comb begin
    sel_addr_vld = 1'b0;
    sel_data_vld = 1'b0;
    sel_addr     = '0;
    sel_size     = '0;
    sel_prot     = '0;
    sel_wdata    = '0;
    sel_so       = 1'b0;
    for (int i = 0; i < ENTRY; i++) begin
      sel_addr_vld = sel_addr_vld | (addr_vld[i] & sel_oh[i]);
      sel_data_vld = sel_data_vld | (data_vld[i] & sel_oh[i]);
      sel_so       = sel_so | (so[i] & sel_oh[i]);
      sel_addr     = sel_addr  | (addr[32*i +: 32]  & {32{sel_oh[i]}});
      sel_size     = sel_size  | (size[2*i +: 2]    & {2{sel_oh[i]}});
      sel_prot     = sel_prot  | (prot[4*i +: 4]    & {4{sel_oh[i]}});
      sel_wdata    = sel_wdata | (wdata[32*i +: 32] & {32{sel_oh[i]}});
    end
  end

endmodule

// File: rtl/pa_lsu_wb_drain.sv
// Drains write-buffer entries in creation order onto AHB-Lite as a write master,
// with pipelined address/data phases, strongly-ordered serialisation and flush.
module pa_lsu_wb_drain
  import pa_lsu_wb_drain_pkg::*;
#(
  parameter int ENTRY = ENTRY_DEF,
  parameter int PTRW  = PTRW_DEF
) (
  input  logic                wb_clk,
  input  logic                cpurst_b,
  input  logic                rtu_yy_xx_async_flush,
  input  logic [ENTRY-1:0]    wb_entry_addr_vld,
  input  logic [ENTRY-1:0]    wb_entry_data_vld,
  input  logic [32*ENTRY-1:0] wb_entry_addr,
  input  logic [2*ENTRY-1:0]  wb_entry_size,
  input  logic [4*ENTRY-1:0]  wb_entry_prot,
  input  logic [32*ENTRY-1:0] wb_entry_wdata,
  input  logic [ENTRY-1:0]    wb_entry_so,
  output logic [ENTRY-1:0]    wb_addr_pop_en,
  output logic [ENTRY-1:0]    wb_data_pop_en,
  output logic [1:0]          lsu_htrans,
  output logic [31:0]         lsu_haddr,
  output logic [2:0]          lsu_hsize,
  output logic                lsu_hwrite,
  output logic [3:0]          lsu_hprot,
  output logic [31:0]         lsu_hwdata,
  input  logic                lsu_hready,
  input  logic                lsu_hresp,
  output logic                lsu_bus_err_vld,
  output logic [31:0]         lsu_bus_err_addr,
  output logic                wb_drain_idle
);

  drain_state_e    state_q, state_d;
  logic [PTRW-1:0] addr_ptr_q, addr_ptr_d;
  logic [PTRW-1:0] data_ptr_q, data_ptr_d;
  logic [PTRW-1:0] dph_idx_q, dph_idx_d;
  logic [31:0]     hwdata_q, hwdata_d;
  logic [31:0]     dph_addr_q, dph_addr_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic            dph_so_q, dph_so_d;
  logic            dph_flushed_q, dph_flushed_d;
  logic            err_vld_q, err_vld_d;

  logic [ENTRY-1:0] sel_oh;
  logic             sel_addr_vld, sel_data_vld, sel_so;
  logic [31:0]      sel_addr, sel_wdata;
  logic [1:0]       sel_size;
  logic [3:0]       sel_prot;

  logic so_block, issue, accepted, dph_done, data_pop;
  logic [ENTRY-1:0] data_oh;

  pa_lsu_wb_drain_mux #(.ENTRY(ENTRY), .PTRW(PTRW)) u_mux (
    .sel_idx      (addr_ptr_q),
    .addr_vld     (wb_entry_addr_vld),
    .data_vld     (wb_entry_data_vld),
    .addr         (wb_entry_addr),
    .size         (wb_entry_size),
    .prot         (wb_entry_prot),
    .wdata        (wb_entry_wdata),
    .so           (wb_entry_so),
    .sel_oh       (sel_oh),
    .sel_addr_vld (sel_addr_vld),
    .sel_data_vld (sel_data_vld),
    .sel_addr     (sel_addr),
    .sel_size     (sel_size),
    .sel_prot     (sel_prot),
    .sel_wdata    (sel_wdata),
    .sel_so       (sel_so)
  );

  // A completing phase that was in flight at flush time still finishes on the bus,
  // but its entry has already been discarded, so its data pop is suppressed.
  always_comb begin
    so_block = (state_q != DRAIN_IDLE) & (sel_so | dph_so_q);
    issue    = sel_addr_vld & sel_data_vld & ~rtu_yy_xx_async_flush & ~so_block
             & ~((state_q == DRAIN_DPH) & lsu_hresp) & (state_q != DRAIN_ERR);
    accepted = issue & lsu_hready;
    dph_done = (state_q != DRAIN_IDLE) & lsu_hready;
    data_pop = dph_done & ~rtu_yy_xx_async_flush & ~dph_flushed_q;
    data_oh             = '0;
    data_oh[data_ptr_q] = data_pop;
  end

  always_comb begin
    state_d       = state_q;
    addr_ptr_d    = addr_ptr_q;
    data_ptr_d    = data_ptr_q;
    dph_idx_d     = dph_idx_q;
    hwdata_d      = hwdata_q;
    dph_addr_d    = dph_addr_q;
    dph_so_d      = dph_so_q;
    dph_flushed_d = dph_flushed_q;
    err_addr_d    = err_addr_q;
    err_vld_d     = 1'b0;

    if (accepted) begin
      addr_ptr_d = addr_ptr_q + 1'b1;
      hwdata_d   = sel_wdata;
      dph_addr_d = sel_addr;
      dph_so_d   = sel_so;
      dph_idx_d  = addr_ptr_q;
    end
    if (data_pop) begin
      data_ptr_d = data_ptr_q + 1'b1;
    end

    case (state_q)
      DRAIN_IDLE: if (accepted) state_d = DRAIN_DPH;
      DRAIN_DPH: begin
        if (lsu_hready)     state_d = accepted ? DRAIN_DPH : DRAIN_IDLE;
        else if (lsu_hresp) state_d = DRAIN_ERR;
      end
      DRAIN_ERR: begin
        if (lsu_hready) begin
          state_d    = DRAIN_IDLE;
          err_vld_d  = 1'b1;
          err_addr_d = dph_addr_q;
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase

    if (dph_done | accepted) dph_flushed_d = 1'b0;
    if (rtu_yy_xx_async_flush) begin
      addr_ptr_d = '0;
      data_ptr_d = '0;
      if ((state_q != DRAIN_IDLE) & ~dph_done) dph_flushed_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q       <= DRAIN_IDLE;
      addr_ptr_q    <= '0;
      data_ptr_q    <= '0;
      dph_idx_q     <= '0;
      hwdata_q      <= '0;
      dph_addr_q    <= '0;
      dph_so_q      <= 1'b0;
      dph_flushed_q <= 1'b0;
      err_addr_q    <= '0;
      err_vld_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_ptr_q    <= addr_ptr_d;
      data_ptr_q    <= data_ptr_d;
      dph_idx_q     <= dph_idx_d;
      hwdata_q      <= hwdata_d;
      dph_addr_q    <= dph_addr_d;
      dph_so_q      <= dph_so_d;
      dph_flushed_q <= dph_flushed_d;
      err_addr_q    <= err_addr_d;
      err_vld_q     <= err_vld_d;
    end
  end

  // The data pointer must always name the entry that owns the live data phase.
  always_ff @(posedge wb_clk) begin
    if (cpurst_b && (state_q != DRAIN_IDLE) && !dph_flushed_q)
      assert (data_ptr_q == dph_idx_q);
  end

  assign wb_addr_pop_en   = accepted ? sel_oh : '0;
  assign wb_data_pop_en   = data_oh;
  assign lsu_htrans       = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign lsu_haddr        = sel_addr;
  assign lsu_hsize        = {1'b0, sel_size};
  assign lsu_hwrite       = 1'b1;
  assign lsu_hprot        = sel_prot;
  assign lsu_hwdata       = hwdata_q;
  assign lsu_bus_err_vld  = err_vld_q;
  assign lsu_bus_err_addr = err_addr_q;
  assign wb_drain_idle    = (state_q == DRAIN_IDLE);

endmodule

// File: tb/tb_pa_lsu_wb_drain.sv
// Directed self-checking bench for the write-buffer drain: single, pipelined,
// wait-state, strongly-ordered, error and wrap/flush scenarios.
module tb_pa_lsu_wb_drain;

  logic         wb_clk;
  logic         cpurst_b;
  logic         rtu_yy_xx_async_flush;
  logic [3:0]   wb_entry_addr_vld;
  logic [3:0]   wb_entry_data_vld;
  logic [127:0] wb_entry_addr;
  logic [7:0]   wb_entry_size;
  logic [15:0]  wb_entry_prot;
  logic [127:0] wb_entry_wdata;
  logic [3:0]   wb_entry_so;
  logic [3:0]   wb_addr_pop_en;
  logic [3:0]   wb_data_pop_en;
  logic [1:0]   lsu_htrans;
  logic [31:0]  lsu_haddr;
  logic [2:0]   lsu_hsize;
  logic         lsu_hwrite;
  logic [3:0]   lsu_hprot;
  logic [31:0]  lsu_hwdata;
  logic         lsu_hready;
  logic         lsu_hresp;
  logic         lsu_bus_err_vld;
  logic [31:0]  lsu_bus_err_addr;
  logic         wb_drain_idle;

  int errors = 0;
  int checks = 0;

  pa_lsu_wb_drain dut (
    .wb_clk                (wb_clk),
    .cpurst_b              (cpurst_b),
    .rtu_yy_xx_async_flush (rtu_yy_xx_async_flush),
    .wb_entry_addr_vld     (wb_entry_addr_vld),
    .wb_entry_data_vld     (wb_entry_data_vld),
    .wb_entry_addr         (wb_entry_addr),
    .wb_entry_size         (wb_entry_size),
    .wb_entry_prot         (wb_entry_prot),
    .wb_entry_wdata        (wb_entry_wdata),
    .wb_entry_so           (wb_entry_so),
    .wb_addr_pop_en        (wb_addr_pop_en),
    .wb_data_pop_en        (wb_data_pop_en),
    .lsu_htrans            (lsu_htrans),
    .lsu_haddr             (lsu_haddr),
    .lsu_hsize             (lsu_hsize),
    .lsu_hwrite            (lsu_hwrite),
    .lsu_hprot             (lsu_hprot),
    .lsu_hwdata            (lsu_hwdata),
    .lsu_hready            (lsu_hready),
    .lsu_hresp             (lsu_hresp),
    .lsu_bus_err_vld       (lsu_bus_err_vld),
    .lsu_bus_err_addr      (lsu_bus_err_addr),
    .wb_drain_idle         (wb_drain_idle)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge wb_clk);
  endtask

  task automatic set_entry(input int idx, input logic [31:0] a, input logic [1:0] sz,
                           input logic [3:0] pr, input logic [31:0] d, input logic so);
    wb_entry_addr[32*idx +: 32]  = a;
    wb_entry_size[2*idx +: 2]    = sz;
    wb_entry_prot[4*idx +: 4]    = pr;
    wb_entry_wdata[32*idx +: 32] = d;
    wb_entry_so[idx]             = so;
    wb_entry_addr_vld[idx]       = 1'b1;
    wb_entry_data_vld[idx]       = 1'b1;
  endtask

  task automatic clear_entry(input int idx);
    wb_entry_addr_vld[idx] = 1'b0;
    wb_entry_data_vld[idx] = 1'b0;
    wb_entry_so[idx]       = 1'b0;
  endtask

  task automatic do_flush();
    rtu_yy_xx_async_flush = 1'b1;
    tick();
    rtu_yy_xx_async_flush = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    cpurst_b = 1'b0;
    sample();
    checks++;
    if ({lsu_htrans, wb_addr_pop_en, wb_data_pop_en, wb_drain_idle, lsu_bus_err_vld, lsu_hwrite} !== {2'b00, 4'b0, 4'b0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b exp %b", {lsu_htrans, wb_addr_pop_en, wb_data_pop_en, wb_drain_idle, lsu_bus_err_vld, lsu_hwrite}, {2'b00, 4'b0, 4'b0, 1'b1, 1'b0, 1'b1});
    end
    checks++;
    if ({lsu_hwdata, lsu_bus_err_addr} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h exp %h", {lsu_hwdata, lsu_bus_err_addr}, 64'h0);
    end
    tick();
    cpurst_b = 1'b1;
    tick();
  endtask

  task automatic test_single_store();
    set_entry(0, 32'h2000_0004, 2'd2, 4'h3, 32'hA5A5_1234, 1'b0);
    sample();
    checks++;
    if ({lsu_htrans, lsu_haddr, lsu_hsize, lsu_hprot, wb_addr_pop_en, wb_data_pop_en} !== {2'b10, 32'h2000_0004, 3'b010, 4'h3, 4'b0001, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL single_addr: got %h exp %h", {lsu_htrans, lsu_haddr, lsu_hsize, lsu_hprot, wb_addr_pop_en, wb_data_pop_en}, {2'b10, 32'h2000_0004, 3'b010, 4'h3, 4'b0001, 4'b0000});
    end
    tick();
    clear_entry(0);
    sample();
    checks++;
    if ({lsu_htrans, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en, wb_drain_idle} !== {2'b00, 32'hA5A5_1234, 4'b0000, 4'b0001, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_data: got %h exp %h", {lsu_htrans, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en, wb_drain_idle}, {2'b00, 32'hA5A5_1234, 4'b0000, 4'b0001, 1'b0});
    end
    tick();
    sample();
    checks++;
    if ({wb_drain_idle, wb_data_pop_en} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL single_idle: got %b exp %b", {wb_drain_idle, wb_data_pop_en}, {1'b1, 4'b0000});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_flush();
    set_entry(0, 32'h0000_1000, 2'd2, 4'h3, 32'h1111_1111, 1'b0);
    set_entry(1, 32'h0000_1004, 2'd1, 4'h3, 32'h2222_2222, 1'b0);
    sample();
    checks++;
    if ({lsu_htrans, lsu_haddr, wb_addr_pop_en, wb_data_pop_en} !== {2'b10, 32'h0000_1000, 4'b0001, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL b2b_c0: got %h exp %h", {lsu_htrans, lsu_haddr, wb_addr_pop_en, wb_data_pop_en}, {2'b10, 32'h0000_1000, 4'b0001, 4'b0000});
    end
    tick();
    clear_entry(0);
    sample();
    checks++;
    if ({lsu_htrans, lsu_haddr, lsu_hsize, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en} !== {2'b10, 32'h0000_1004, 3'b001, 32'h1111_1111, 4'b0010, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL b2b_c1: got %h exp %h", {lsu_htrans, lsu_haddr, lsu_hsize, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en}, {2'b10, 32'h0000_1004, 3'b001, 32'h1111_1111, 4'b0010, 4'b0001});
    end
    tick();
    clear_entry(1);
    sample();
    checks++;
    if ({lsu_htrans, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en} !== {2'b00, 32'h2222_2222, 4'b0000, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL b2b_c2: got %h exp %h", {lsu_htrans, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en}, {2'b00, 32'h2222_2222, 4'b0000, 4'b0010});
    end
    tick();
  endtask

  task automatic test_wait_states();
    do_flush();
    set_entry(0, 32'h0000_3000, 2'd2, 4'h1, 32'h3333_3333, 1'b0);
    set_entry(1, 32'h0000_3004, 2'd2, 4'h1, 32'h4444_4444, 1'b0);
    tick();
    clear_entry(0);
    lsu_hready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      sample();
      checks++;
      if ({lsu_htrans, lsu_haddr, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en} !== {2'b10, 32'h0000_3004, 32'h3333_3333, 4'b0000, 4'b0000}) begin
        errors++;
        $display("[TB] FAIL wait_hold%0d: got %h exp %h", w, {lsu_htrans, lsu_haddr, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en}, {2'b10, 32'h0000_3004, 32'h3333_3333, 4'b0000, 4'b0000});
      end
      tick();
    end
    lsu_hready = 1'b1;
    sample();
    checks++;
    if ({wb_addr_pop_en, wb_data_pop_en} !== {4'b0010, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL wait_release: got %b exp %b", {wb_addr_pop_en, wb_data_pop_en}, {4'b0010, 4'b0001});
    end
    tick();
    clear_entry(1);
    sample();
    checks++;
    if ({lsu_hwdata, wb_data_pop_en} !== {32'h4444_4444, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL wait_last: got %h exp %h", {lsu_hwdata, wb_data_pop_en}, {32'h4444_4444, 4'b0010});
    end
    tick();
  endtask

  task automatic test_strongly_ordered();
    do_flush();
    set_entry(0, 32'h0000_5000, 2'd2, 4'h3, 32'h5555_0000, 1'b0);
    set_entry(1, 32'h0000_5004, 2'd2, 4'h3, 32'h5555_0001, 1'b1);
    set_entry(2, 32'h0000_5008, 2'd2, 4'h3, 32'h5555_0002, 1'b0);
    sample();
    checks++;
    if ({lsu_htrans, wb_addr_pop_en} !== {2'b10, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL so_c0: got %b exp %b", {lsu_htrans, wb_addr_pop_en}, {2'b10, 4'b0001});
    end
    tick();
    clear_entry(0);
    sample();
    checks++;
    if ({lsu_htrans, wb_addr_pop_en, wb_data_pop_en} !== {2'b00, 4'b0000, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL so_block_in: got %b exp %b", {lsu_htrans, wb_addr_pop_en, wb_data_pop_en}, {2'b00, 4'b0000, 4'b0001});
    end
    tick();
    sample();
    checks++;
    if ({lsu_htrans, lsu_haddr, wb_addr_pop_en} !== {2'b10, 32'h0000_5004, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL so_issue: got %h exp %h", {lsu_htrans, lsu_haddr, wb_addr_pop_en}, {2'b10, 32'h0000_5004, 4'b0010});
    end
    tick();
    clear_entry(1);
    sample();
    checks++;
    if ({lsu_htrans, wb_addr_pop_en, wb_data_pop_en} !== {2'b00, 4'b0000, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL so_block_out: got %b exp %b", {lsu_htrans, wb_addr_pop_en, wb_data_pop_en}, {2'b00, 4'b0000, 4'b0010});
    end
    tick();
    sample();
    checks++;
    if ({lsu_htrans, lsu_haddr, wb_addr_pop_en} !== {2'b10, 32'h0000_5008, 4'b0100}) begin
      errors++;
      $display("[TB] FAIL so_next: got %h exp %h", {lsu_htrans, lsu_haddr, wb_addr_pop_en}, {2'b10, 32'h0000_5008, 4'b0100});
    end
    tick();
    clear_entry(2);
    tick();
  endtask

  task automatic test_error();
    do_flush();
    set_entry(0, 32'h4000_0000, 2'd2, 4'h3, 32'hDEAD_BEEF, 1'b0);
    tick();
    clear_entry(0);
    set_entry(1, 32'h4000_0004, 2'd2, 4'h3, 32'hCAFE_0001, 1'b0);
    lsu_hready = 1'b0;
    lsu_hresp  = 1'b1;
    sample();
    checks++;
    if ({lsu_htrans, wb_addr_pop_en, wb_data_pop_en, lsu_bus_err_vld} !== {2'b00, 4'b0000, 4'b0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL err_first: got %b exp %b", {lsu_htrans, wb_addr_pop_en, wb_data_pop_en, lsu_bus_err_vld}, {2'b00, 4'b0000, 4'b0000, 1'b0});
    end
    tick();
    lsu_hready = 1'b1;
    sample();
    checks++;
    if ({lsu_htrans, wb_addr_pop_en, wb_data_pop_en, wb_drain_idle} !== {2'b00, 4'b0000, 4'b0001, 1'b0}) begin
      errors++;
      $display("[TB] FAIL err_second: got %b exp %b", {lsu_htrans, wb_addr_pop_en, wb_data_pop_en, wb_drain_idle}, {2'b00, 4'b0000, 4'b0001, 1'b0});
    end
    tick();
    lsu_hresp = 1'b0;
    sample();
    checks++;
    if ({lsu_bus_err_vld, lsu_bus_err_addr} !== {1'b1, 32'h4000_0000}) begin
      errors++;
      $display("[TB] FAIL err_report: got %h exp %h", {lsu_bus_err_vld, lsu_bus_err_addr}, {1'b1, 32'h4000_0000});
    end
    checks++;
    if ({lsu_htrans, lsu_haddr, wb_addr_pop_en} !== {2'b10, 32'h4000_0004, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL err_resume: got %h exp %h", {lsu_htrans, lsu_haddr, wb_addr_pop_en}, {2'b10, 32'h4000_0004, 4'b0010});
    end
    tick();
    clear_entry(1);
    sample();
    checks++;
    if ({lsu_bus_err_vld, wb_data_pop_en} !== {1'b0, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL err_pulse_end: got %b exp %b", {lsu_bus_err_vld, wb_data_pop_en}, {1'b0, 4'b0010});
    end
    tick();
  endtask

  task automatic test_wrap_flush();
    logic [3:0] exp_oh;
    logic [3:0] prev_oh;
    do_flush();
    set_entry(0, 32'h0000_6000, 2'd2, 4'h3, 32'h6000_0000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      exp_oh  = 4'b0001 << (k % 4);
      prev_oh = 4'b0001 << ((k + 3) % 4);
      sample();
      checks++;
      if ({lsu_htrans, lsu_haddr, wb_addr_pop_en} !== {2'b10, 32'h0000_6000 + 32'(4 * k), exp_oh}) begin
        errors++;
        $display("[TB] FAIL wrap_addr%0d: got %h exp %h", k, {lsu_htrans, lsu_haddr, wb_addr_pop_en}, {2'b10, 32'h0000_6000 + 32'(4 * k), exp_oh});
      end
      if (k > 0) begin
        checks++;
        if ({lsu_hwdata, wb_data_pop_en} !== {32'h6000_0000 + 32'(k - 1), prev_oh}) begin
          errors++;
          $display("[TB] FAIL wrap_data%0d: got %h exp %h", k, {lsu_hwdata, wb_data_pop_en}, {32'h6000_0000 + 32'(k - 1), prev_oh});
        end
      end
      tick();
      clear_entry(k % 4);
      if (k < 5) set_entry((k + 1) % 4, 32'h0000_6000 + 32'(4 * (k + 1)), 2'd2, 4'h3, 32'h6000_0000 + 32'(k + 1), 1'b0);
    end
    rtu_yy_xx_async_flush = 1'b1;
    set_entry(2, 32'h0000_7008, 2'd2, 4'h3, 32'h7000_0002, 1'b0);
    sample();
    checks++;
    if ({lsu_htrans, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en} !== {2'b00, 32'h6000_0005, 4'b0000, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL flush_cycle: got %h exp %h", {lsu_htrans, lsu_hwdata, wb_addr_pop_en, wb_data_pop_en}, {2'b00, 32'h6000_0005, 4'b0000, 4'b0000});
    end
    tick();
    rtu_yy_xx_async_flush = 1'b0;
    set_entry(0, 32'h0000_7000, 2'd2, 4'h3, 32'h7000_0000, 1'b0);
    sample();
    checks++;
    if ({wb_drain_idle, lsu_htrans, lsu_haddr, wb_addr_pop_en} !== {1'b1, 2'b10, 32'h0000_7000, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL flush_ptr: got %h exp %h", {wb_drain_idle, lsu_htrans, lsu_haddr, wb_addr_pop_en}, {1'b1, 2'b10, 32'h0000_7000, 4'b0001});
    end
    tick();
    clear_entry(0);
    clear_entry(2);
    sample();
    checks++;
    if ({lsu_hwdata, wb_data_pop_en} !== {32'h7000_0000, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL flush_dptr: got %h exp %h", {lsu_hwdata, wb_data_pop_en}, {32'h7000_0000, 4'b0001});
    end
    tick();
  endtask

  initial begin
    cpurst_b              = 1'b0;
    rtu_yy_xx_async_flush = 1'b0;
    wb_entry_addr_vld     = '0;
    wb_entry_data_vld     = '0;
    wb_entry_addr         = '0;
    wb_entry_size         = '0;
    wb_entry_prot         = '0;
    wb_entry_wdata        = '0;
    wb_entry_so           = '0;
    lsu_hready            = 1'b1;
    lsu_hresp             = 1'b0;
    test_reset();
    test_single_store();
    test_back_to_back();
    test_wait_states();
    test_strongly_ordered();
    test_error();
    test_wrap_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pa_lsu_wb_drain.md
Name: pa_lsu_wb_drain

Overview:
- Bus-side consumer of the LSU write-buffer entries: drains stores in creation order onto the AHB-Lite data bus as a master.
- Drives the address phase from the oldest addr-ready entry and the data phase from a registered copy of its write data.
- Returns per-entry one-hot addr-pop and data-pop strobes back to the entries.
- Handles strongly-ordered (SO) serialisation, the two-cycle ERROR response and async flush.

Parameters:
ENTRY, 4, number of write-buffer entries drained (power of 2)
PTRW, 2, log2(ENTRY) pointer width

Ports:
wb_clk  input  1  clock
cpurst_b  input  1  asynchronous active-low reset
rtu_yy_xx_async_flush  input  1  flush all entries and pointers
wb_entry_addr_vld  input  ENTRY  per-entry address ready (already gated by src1 dependency)
wb_entry_data_vld  input  ENTRY  per-entry data ready
wb_entry_addr  input  32*ENTRY  flattened entry addresses
wb_entry_size  input  2*ENTRY  flattened sizes (0 B, 1 H, 2 W)
wb_entry_prot  input  4*ENTRY  flattened hprot
wb_entry_wdata  input  32*ENTRY  flattened write data
wb_entry_so  input  ENTRY  per-entry strongly-ordered flag
wb_addr_pop_en  output  ENTRY  one-hot address-phase accepted
wb_data_pop_en  output  ENTRY  one-hot data-phase completed
lsu_htrans  output  2  2'b10 NONSEQ or 2'b00 IDLE
lsu_haddr  output  32  address
lsu_hsize  output  3  {1'b0,size}
lsu_hwrite  output  1  constant 1
lsu_hprot  output  4  prot of issued entry
lsu_hwdata  output  32  registered write data
lsu_hready  input  1  AHB hready
lsu_hresp  input  1  AHB hresp (1 = ERROR)
lsu_bus_err_vld  output  1  one-cycle pulse, store bus error
lsu_bus_err_addr  output  32  address of faulting store
wb_drain_idle  output  1  no data phase outstanding

Behaviour:
- Reset: addr_ptr = data_ptr = 0; state IDLE; hwdata_q = 0; err_addr = 0; htrans = IDLE; all pops 0; err_vld 0; wb_drain_idle 1.
- Issue condition (combinational): ent = addr_ptr; issue = addr_vld[ent] & data_vld[ent] & !flush & !so_block & !(state==DPH & hresp) & state!=ERR.
- so_block = (state!=IDLE) & (so[ent] | dph_so): an SO entry is never overlapped with a prior data phase, and nothing is overlapped behind an SO entry.
- When issue: htrans = NONSEQ; haddr, hsize, hprot from entry ent; otherwise htrans = IDLE and haddr = entry ent (don't care).
- Address accepted = issue & hready:
  - wb_addr_pop_en[ent] = 1 the same cycle.
  - addr_ptr+1 (wraps ENTRY-1 -> 0).
  - hwdata_q <= wdata[ent]; dph_addr <= addr; dph_so <= so[ent]; dph_idx <= ent; state <= DPH.
- FSM states:
  - IDLE: go to DPH on address accepted.
  - DPH, hready & !hresp: wb_data_pop_en[data_ptr] = 1; data_ptr+1; next state is DPH if a new address was accepted this cycle (pipelined overlap), else IDLE.
  - DPH, !hready & hresp (ERROR first cycle): go to ERR; htrans forced IDLE.
  - DPH, !hready & !hresp: wait state; hold everything, including haddr/htrans of any pending NONSEQ.
  - ERR: expects hready & hresp. Pulse err_vld, err_addr = dph_addr; data pop and data_ptr+1 as normal. Go to IDLE (no issue in ERR cycle).
  - ERR with hready = 0: stay in ERR.
- Data pop always targets data_ptr. Invariant: data_ptr == dph_idx. Simultaneous addr pop and data pop on different entries is legal.
- Flush:
  - Same cycle: htrans = IDLE, no addr pop.
  - Next cycle: addr_ptr = data_ptr = 0.
  - An in-flight data phase completes on the bus from hwdata_q with data pop suppressed; its error is still reported.
- Ordering: every entry is popped address-then-data, strictly in pointer order.
- wb_drain_idle = (state==IDLE).

Decomposition:
- Shared LSU package: HTRANS_IDLE/NONSEQ constants, FSM state encoding (IDLE/DPH/ERR), ENTRY/PTRW defaults.
- Sub-module pa_lsu_wb_drain_mux: ENTRY:1 one-hot/index mux for addr/size/prot/wdata/so.
- All sequential logic on wb_clk with cpurst_b asynchronous.

Test Plan:
- Single store: entry0 addr 0x2000_0004, size 2, wdata 0xA5A5_1234, hready=1 -> cycle0 NONSEQ + addr_pop[0]; cycle1 hwdata 0xA5A5_1234 + data_pop[0]; idle cycle2.
- Pipelined stores: entries 0 and 1 ready, hready=1 -> back-to-back NONSEQ, data phase of entry0 overlaps address of entry1, pops 0 then 1 each one cycle apart.
- Wait states: hready=0 for 3 cycles during entry0 data phase with entry1 pending -> haddr/htrans held stable, no pops, then data_pop[0] and addr_pop[1] in the same cycle.
- SO: entry1 so=1 -> entry1 NONSEQ only after data_pop[0]; entry2 not issued until data_pop[1].
- Error: hresp=1/hready=0 then hresp=1/hready=1 on entry0 at 0x4000_0000 -> htrans IDLE both cycles, err_vld pulse, err_addr 0x4000_0000, data_pop[0].
- Wrap + flush: 6 stores wrap pointers 3->0; flush during data phase -> phase completes without data pop, pointers 0, wb_drain_idle=1 next cycle.
